// File: rtl/led_spin_engine.sv
// Rotating LED pattern engine: a base-tick prescaler and a speed-scaled step counter
// drive an 8-position pointer rendered as dot, fill, bounce or pair patterns.
module led_spin_engine #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] speed,
    input  logic       dir,
    input  logic [1:0] mode,
    input  logic       pause,
    input  logic       step_req,
    output logic [7:0] led,
    output logic [2:0] pos,
    output logic       step_strobe
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    localparam logic [1:0] MODE_DOT    = 2'b00;
    localparam logic [1:0] MODE_FILL   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_PAIR   = 2'b11;

    logic [15:0] presc_q;
    logic [3:0]  step_cnt_q;
    logic        phase_q;
    logic        bdir_q;
    logic [1:0]  mode_q;

    logic        base_tick;
    logic        auto_adv;
    logic        advance;
    logic        mode_chg;
    logic        bdir_entry;
    logic        bdir_eff;
    logic        phase_base;
    logic [2:0]  pos_nxt;
    logic        bdir_nxt;
    logic        phase_nxt;
    logic [7:0]  led_nxt;

    function automatic logic [7:0] led_pattern(input logic [1:0] m, input logic [2:0] p,
                                               input logic ph);
        logic [7:0] therm;
        logic [7:0] pat;
        therm = 8'hFF >> (3'd7 - p);
        pat   = 8'h01 << p;
        case (m)
            MODE_FILL: pat = ph ? ~therm : therm;
            MODE_PAIR: pat = (8'h01 << p) | (8'h01 << 3'(p + 3'd1));
            default:   pat = 8'h01 << p;
        endcase
        return pat;
    endfunction

    always_comb begin
        base_tick  = !pause && (presc_q == TICK_LAST);
        // ">=" lets a speed lowered below the running count fire on the next tick
        auto_adv   = base_tick && (step_cnt_q >= speed);
        advance    = ena && (pause ? step_req : auto_adv);
        mode_chg   = (mode != mode_q);

        // Entering bounce: follow dir, but never start pointing off the end of the bar
        bdir_entry = dir;
        if (pos == 3'd7 && dir)
            bdir_entry = 1'b0;
        else if (pos == 3'd0 && !dir)
            bdir_entry = 1'b1;
        bdir_eff   = (mode_chg && mode == MODE_BOUNCE) ? bdir_entry : bdir_q;
        phase_base = mode_chg ? 1'b0 : phase_q;

        pos_nxt    = pos;
        bdir_nxt   = bdir_eff;
        phase_nxt  = phase_base;

        if (advance) begin
            if (mode == MODE_BOUNCE) begin
                pos_nxt = bdir_eff ? pos + 3'd1 : pos - 3'd1;
                if (bdir_eff && pos_nxt == 3'd7)
                    bdir_nxt = 1'b0;
                else if (!bdir_eff && pos_nxt == 3'd0)
                    bdir_nxt = 1'b1;
            end else begin
                pos_nxt = dir ? pos + 3'd1 : pos - 3'd1;
                if (mode == MODE_FILL && ((dir && pos == 3'd7) || (!dir && pos == 3'd0)))
                    phase_nxt = ~phase_base;
            end
        end

        led_nxt = led_pattern(mode, pos_nxt, phase_nxt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q     <= 16'd0;
            step_cnt_q  <= 4'd0;
            pos         <= 3'd0;
            phase_q     <= 1'b0;
            bdir_q      <= 1'b1;
            mode_q      <= MODE_DOT;
            led         <= 8'h01;
            step_strobe <= 1'b0;
        end else if (ena) begin
            if (!pause) begin
                presc_q <= base_tick ? 16'd0 : 16'(presc_q + 16'd1);
                if (base_tick)
                    step_cnt_q <= auto_adv ? 4'd0 : 4'(step_cnt_q + 4'd1);
            end
            pos         <= pos_nxt;
            phase_q     <= phase_nxt;
            bdir_q      <= bdir_nxt;
            mode_q      <= mode;
            led         <= led_nxt;
            step_strobe <= advance;
        end else begin
            step_strobe <= 1'b0;
        end
    end

endmodule
